sysid_checker_master: RTL

- Avalon-MM read master that queries the system ID peripheral: word 0 = system ID, word 1 = build timestamp.
- Compares both words against build-time expected values and reports match, mismatch or timeout to the frame-buffering control logic.
- Runs once automatically after reset and again on each start pulse.
- Sits on the Qsys interconnect beside the CPU master and gates frame-buffer enable until the hardware/software build pairing is confirmed.

---
 rtl/sysid_checker_master.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sysid_checker_master.sv
// Avalon-MM read master that fetches the system ID and build timestamp
// words and checks them against the values this image was built with.
module sysid_checker_master #(
  parameter logic [31:0] EXPECTED_ID        = 32'h00000000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1496327636,
  parameter int          TIMEOUT_CYCLES     = 1024,
  parameter int          MAX_RETRIES        = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    IDLE, AUTO_START, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, FINISH
  } state_t;

  localparam logic [15:0] CNT_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

  state_t      state_q, state_d;
  logic        read_q, read_d;
  logic        addr_q, addr_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        tmo_q, tmo_d;
  logic [31:0] id_val_q, id_val_d;
  logic [31:0] ts_val_q, ts_val_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;

  logic is_req, is_wait, is_ts;
  logic accept, data, expired;

  always_comb begin
    is_req  = (state_q == ID_REQ) || (state_q == TS_REQ);
    is_wait = (state_q == ID_WAIT) || (state_q == TS_WAIT);
    is_ts   = (state_q == TS_REQ) || (state_q == TS_WAIT);
    accept  = is_req && read_q && !avm_waitrequest;
    // A zero-latency slave may return data in the accept cycle
    data    = avm_readdatavalid && (is_wait || accept);
    expired = (is_req || is_wait) && (cnt_q == CNT_LAST);
  end

  always_comb begin
    state_d  = state_q;
    read_d   = read_q;
    addr_d   = addr_q;
    done_d   = 1'b0;
    id_ok_d  = id_ok_q;
    ts_ok_d  = ts_ok_q;
    tmo_d    = tmo_q;
    id_val_d = id_val_q;
    ts_val_d = ts_val_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    unique case (state_q)
      IDLE, AUTO_START: begin
        if (start || state_q == AUTO_START) begin
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
          tmo_d   = 1'b0;
          retry_d = 4'd0;
          cnt_d   = 16'd0;
          read_d  = 1'b1;
          addr_d  = 1'b0;
          state_d = ID_REQ;
        end
      end
      ID_REQ, ID_WAIT, TS_REQ, TS_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (data) begin
          read_d  = 1'b0;
          retry_d = 4'd0;
          if (is_ts) begin
            ts_val_d = avm_readdata;
            ts_ok_d  = (avm_readdata == EXPECTED_TIMESTAMP);
            state_d  = FINISH;
          end else begin
            id_val_d = avm_readdata;
            id_ok_d  = (avm_readdata == EXPECTED_ID);
            cnt_d    = 16'd0;
            read_d   = 1'b1;
            addr_d   = 1'b1;
            state_d  = TS_REQ;
          end
        end else if (expired) begin
          // Re-enter REQ with read low; it is raised a cycle later
          read_d = 1'b0;
          cnt_d  = 16'd0;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 4'd1;
            state_d = is_ts ? TS_REQ : ID_REQ;
          end else begin
            tmo_d   = 1'b1;
            state_d = FINISH;
          end
        end else if (accept) begin
          read_d  = 1'b0;
          state_d = is_ts ? TS_WAIT : ID_WAIT;
        end else if (is_req && !read_q) begin
          read_d = 1'b1;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= AUTO_START;
      read_q   <= 1'b0;
      addr_q   <= 1'b0;
      done_q   <= 1'b0;
      id_ok_q  <= 1'b0;
      ts_ok_q  <= 1'b0;
      tmo_q    <= 1'b0;
      id_val_q <= 32'd0;
      ts_val_q <= 32'd0;
      cnt_q    <= 16'd0;
      retry_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      read_q   <= read_d;
      addr_q   <= addr_d;
      done_q   <= done_d;
      id_ok_q  <= id_ok_d;
      ts_ok_q  <= ts_ok_d;
      tmo_q    <= tmo_d;
      id_val_q <= id_val_d;
      ts_val_q <= ts_val_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
    end
  end

  assign avm_read    = read_q;
  assign avm_address = addr_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = tmo_q;
  assign id_value    = id_val_q;
  assign ts_value    = ts_val_q;

endmodule
